cosine_sequencer: RTL and testbench
===================================

Name: cosine_sequencer

Overview:
- Control FSM that drives the cosine/distance datapath through its 4-bit `state` bus and watches its `stop`/`done` returns.
- Upstream side: req/ack handshake to start a computation. Downstream side: valid/ready handshake that presents the finished distance.
- Adds a loop watchdog and a done check so that a hung or inconsistent datapath raises `error` instead of stalling.

Parameters:
- MAX_LOOPS, 16: Remult cycles allowed without `stop` before abort (must be ≥ 8).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  start request; level, sampled each cycle.
- ack  out  1  one-cycle pulse when req is accepted.
- stop  in  1  datapath term-counter reached 8.
- done  in  1  datapath Done register output.
- state  out  4  datapath control code: 0 StandBy, 1 Alert, 2 StartCalculation, 3 AccumulateTerms, 4 CalculateDistance, 5 Remult.
- busy  out  1  high in any state other than StandBy.
- result_valid  out  1  distance output of datapath is valid.
- result_ready  in  1  consumer accepts result.
- error  out  1  sticky fault flag.

Behaviour:
- Reset (synchronous, active-high): state=0, ack=0, busy=0, result_valid=0, error=0, loop count=0, internal pending flag=0. Reset wins over all other inputs in that cycle, including mid-computation. After reset, a stale datapath `done`=1 never produces result_valid.
- STANDBY (code 0): req is accepted when no result is pending, or when the pending result is consumed in the same cycle (result_valid&result_ready). On acceptance: ack=1 that cycle; next state ALERT; error cleared. Otherwise req is ignored and ack=0.
- ALERT (1): single cycle; upstream vSig/XSig must be stable from here through START. Next state START.
- START (2): single cycle; datapath loads V, X2, term=1.0, expression=0, counter=0 and clears Done. Loop count cleared. Next state ACCUM.
- ACCUM (3): always goes to REMULT next.
- REMULT (5): loop count increments. If stop=1, next state DIST. Else if loop count has reached MAX_LOOPS, set error and go to STANDBY with no result. Else go to ACCUM.
- DIST (4): single cycle; next state STANDBY; internal check flag set.
- Check cycle (first STANDBY cycle after DIST):
  - done=1: result_valid rises and pending flag is set.
  - done=0: error is set and no result is presented.
- result_valid stays high until the first cycle in which result_ready=1; it drops on the following edge. result_ready while result_valid=0 has no effect.
- Timing (req accepted at cycle T): ALERT T+1, START T+2, ACCUM at T+3, T+5 … T+17, REMULT at T+4 … T+18, DIST T+19, result_valid=1 from T+20. busy=1 for T+1..T+19.
- stop is only evaluated in REMULT; stop=1 in any other state is ignored.
- The state output is registered and always shows a legal code 0–5. The FSM holds no other encodings.

Test Plan:
- Nominal run: reset, then req=1 for 1 cycle with a datapath model that raises stop after 8 ACCUMs -> ack at T; state sequence 0,1,2,3,5,3,5…3,5,4,0; DIST at T+19; result_valid=1 at T+20; error=0.
- Backpressure: hold result_ready=0 for 5 cycles after valid -> result_valid stays 1; req during that window gives ack=0. Assert ready and req together -> valid drops and ack=1 in the same cycle.
- Timeout: stop tied 0, MAX_LOOPS=16 -> after the 16th REMULT, state=0 and error=1; result_valid never rises. The next accepted req clears error.
- Done fault: datapath holds done=0 through DIST -> error=1 at T+20, result_valid=0.
- Reset mid-run: assert reset during the 3rd ACCUM -> state=0, busy=0, result_valid=0 after that edge. A stale done=1 afterwards does not raise result_valid.
- Spurious stop: stop=1 during ALERT/START/ACCUM -> no early DIST; sequence proceeds to the first REMULT.

Source files
------------

// File: rtl/cosine_sequencer_if.sv
// rtl/cosine_sequencer_if.sv - handshake and datapath control bundle for cosine_sequencer
interface cosine_sequencer_if;
    logic       req;
    logic       ack;
    logic       stop;
    logic       done;
    logic [3:0] state;
    logic       busy;
    logic       result_valid;
    logic       result_ready;
    logic       error;

    // master: the sequencer; slave: upstream requester, datapath and result consumer
    modport master (
        input  req, stop, done, result_ready,
        output ack, state, busy, result_valid, error
    );

    modport slave (
        output req, stop, done, result_ready,
        input  ack, state, busy, result_valid, error
    );
endinterface

// File: rtl/cosine_sequencer.sv
// rtl/cosine_sequencer.sv - control FSM for the cosine/distance datapath with loop watchdog and done check
module cosine_sequencer #(
    parameter int MAX_LOOPS = 16    // must be >= 8, the datapath needs eight ACCUM/REMULT passes
) (
    input  logic               clk,
    input  logic               reset,
    cosine_sequencer_if.master bus
);
    localparam int CW = $clog2(MAX_LOOPS + 1);
    localparam logic [CW-1:0] LOOP_LIMIT = CW'(MAX_LOOPS);

    typedef enum logic [3:0] {
        STANDBY = 4'd0,
        ALERT   = 4'd1,
        START   = 4'd2,
        ACCUM   = 4'd3,
        DIST    = 4'd4,
        REMULT  = 4'd5
    } state_t;

    state_t          state_q;
    state_t          state_next;
    logic [CW-1:0]   loop_count;
    logic [CW-1:0]   loop_inc;
    logic            pending;
    logic            check;
    logic            error_q;
    logic            valid;
    logic            accept;
    logic            timeout;

    assign loop_inc = loop_count + CW'(1);

    // The datapath's Done register is only trusted in the cycle right after DIST,
    // so a stale done=1 outside that window never produces a result.
    assign valid = pending | (check & bus.done);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STANDBY;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        state_next = state_q;
        accept     = 1'b0;
        timeout    = 1'b0;
        unique case (state_q)
            STANDBY: begin
                if (bus.req && (!valid || bus.result_ready)) begin
                    accept     = 1'b1;
                    state_next = ALERT;
                end
            end
            ALERT:   state_next = START;
            START:   state_next = ACCUM;
            ACCUM:   state_next = REMULT;
            REMULT: begin
                if (bus.stop) begin
                    state_next = DIST;
                end else if (loop_inc >= LOOP_LIMIT) begin
                    timeout    = 1'b1;
                    state_next = STANDBY;
                end else begin
                    state_next = ACCUM;
                end
            end
            DIST:    state_next = STANDBY;
            default: state_next = STANDBY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            loop_count <= '0;
            pending    <= 1'b0;
            check      <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            check <= (state_q == DIST);

            if (state_q == START) begin
                loop_count <= '0;
            end else if (state_q == REMULT) begin
                loop_count <= loop_inc;
            end

            if (valid && bus.result_ready) begin
                pending <= 1'b0;
            end else if (check && bus.done) begin
                pending <= 1'b1;
            end

            if (accept) begin
                error_q <= 1'b0;
            end else if (timeout || (check && !bus.done)) begin
                error_q <= 1'b1;
            end
        end
    end

    assign bus.ack          = accept;
    assign bus.state        = state_q;
    assign bus.busy         = (state_q != STANDBY);
    assign bus.result_valid = valid;
    assign bus.error        = error_q | (check & ~bus.done);
endmodule

// File: tb/tb_cosine_sequencer.sv
// tb/tb_cosine_sequencer.sv - scoreboard bench for cosine_sequencer with directed per-cycle vectors
module tb_cosine_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cosine_sequencer_if bus();

    cosine_sequencer #(.MAX_LOOPS(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] state;
        logic       ack;
        logic       busy;
        logic       valid;
        logic       error;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    n_pass  = 0;
    int    n_total = 0;

    // Monitor: pops one expectation per presented cycle and compares mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            obs_t  e;
            obs_t  a;
            string nm;
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            a.state = bus.state;
            a.ack   = bus.ack;
            a.busy  = bus.busy;
            a.valid = bus.result_valid;
            a.error = bus.error;
            n_total++;
            if (a === e) begin
                n_pass++;
            end else begin
                $display("FAIL %s @%0t: got state=%0d ack=%b busy=%b valid=%b error=%b, want state=%0d ack=%b busy=%b valid=%b error=%b",
                         nm, $time, a.state, a.ack, a.busy, a.valid, a.error,
                         e.state, e.ack, e.busy, e.valid, e.error);
            end
        end
    end

    task automatic cyc(input logic rst, input logic rq, input logic st, input logic dn,
                       input logic rdy, input logic [3:0] s, input logic a, input logic b,
                       input logic v, input logic e, input string nm);
        obs_t x;
        reset            = rst;
        bus.req          = rq;
        bus.stop         = st;
        bus.done         = dn;
        bus.result_ready = rdy;
        x.state = s; x.ack = a; x.busy = b; x.valid = v; x.error = e;
        exp_q.push_back(x);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // ALERT through the check cycle of one accepted computation.
    task automatic body(input logic spur, input logic good);
        cyc(0, 0, spur, 0, 0, 4'd1, 0, 1, 0, 0, "alert");
        cyc(0, 0, spur, 0, 0, 4'd2, 0, 1, 0, 0, "start");
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, spur && (i == 0), 0, 0, 4'd3, 0, 1, 0, 0, "accum");
            cyc(0, 0, (i == 7), 0, 0, 4'd5, 0, 1, 0, 0, "remult");
        end
        cyc(0, 0, 0, 0, 0, 4'd4, 0, 1, 0, 0, "dist");
        cyc(0, 0, 0, good, 0, 4'd0, 0, 0, good, !good, "check_cycle");
    endtask

    initial begin
        bus.req = 0; bus.stop = 0; bus.done = 0; bus.result_ready = 0;
        repeat (2) @(posedge clk);
        #1;

        cyc(0, 0, 0, 1, 1, 4'd0, 0, 0, 0, 0, "reset_state");

        // Nominal run followed by backpressure on the result
        cyc(0, 1, 0, 0, 0, 4'd0, 1, 0, 0, 0, "accept_nominal");
        body(0, 1);
        cyc(0, 0, 0, 1, 0, 4'd0, 0, 0, 1, 0, "hold_valid");
        cyc(0, 1, 0, 1, 0, 4'd0, 0, 0, 1, 0, "req_blocked");
        cyc(0, 1, 0, 1, 0, 4'd0, 0, 0, 1, 0, "req_blocked");
        cyc(0, 0, 0, 1, 0, 4'd0, 0, 0, 1, 0, "hold_valid");
        cyc(0, 1, 0, 1, 1, 4'd0, 1, 0, 1, 0, "consume_and_accept");

        // Spurious stop early, then a done fault
        body(1, 0);
        cyc(0, 0, 0, 0, 0, 4'd0, 0, 0, 0, 1, "error_sticky");
        cyc(0, 1, 0, 0, 0, 4'd0, 1, 0, 0, 1, "accept_after_fault");
        body(0, 1);
        cyc(0, 0, 0, 1, 1, 4'd0, 0, 0, 1, 0, "pending_consumed");
        cyc(0, 0, 0, 1, 0, 4'd0, 0, 0, 0, 0, "valid_dropped");
        cyc(0, 0, 0, 0, 1, 4'd0, 0, 0, 0, 0, "ready_without_valid");

        // Watchdog timeout with stop held low
        cyc(0, 1, 0, 0, 0, 4'd0, 1, 0, 0, 0, "accept_timeout");
        cyc(0, 0, 0, 0, 0, 4'd1, 0, 1, 0, 0, "alert");
        cyc(0, 0, 0, 0, 0, 4'd2, 0, 1, 0, 0, "start");
        for (int i = 0; i < 16; i++) begin
            cyc(0, 0, 0, 0, 0, 4'd3, 0, 1, 0, 0, "to_accum");
            cyc(0, 0, 0, 0, 0, 4'd5, 0, 1, 0, 0, "to_remult");
        end
        cyc(0, 0, 0, 1, 0, 4'd0, 0, 0, 0, 1, "timeout_error");
        cyc(0, 0, 0, 1, 0, 4'd0, 0, 0, 0, 1, "timeout_no_valid");

        // Accept clears error, then reset during the third ACCUM
        cyc(0, 1, 0, 0, 0, 4'd0, 1, 0, 0, 1, "accept_clears_error");
        cyc(0, 0, 0, 0, 0, 4'd1, 0, 1, 0, 0, "alert_error_clear");
        cyc(0, 0, 0, 0, 0, 4'd2, 0, 1, 0, 0, "start");
        cyc(0, 0, 0, 0, 0, 4'd3, 0, 1, 0, 0, "accum");
        cyc(0, 0, 0, 0, 0, 4'd5, 0, 1, 0, 0, "remult");
        cyc(0, 0, 0, 0, 0, 4'd3, 0, 1, 0, 0, "accum");
        cyc(0, 0, 0, 0, 0, 4'd5, 0, 1, 0, 0, "remult");
        cyc(1, 0, 0, 0, 0, 4'd3, 0, 1, 0, 0, "accum_at_reset");
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 0, 4'd0, 0, 0, 0, 0, "after_reset_stale_done");
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
